cmp_sched: RTL and testbench

Two-requester scheduler that shares one signed greater-than comparator between the branch unit (port 0) and the ALU set-less-than path (port 1). It accepts compare requests over a valid/ready handshake with round-robin arbitration, sequences the comparator over one or two passes depending on the operation, and returns a single-bit result over a held response channel tagged with the requester ID. It sits beside the ALU in the execute stage.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/cmp_gt.sv | 25 ++
 rtl/cmp_sched.sv | 165 ++++++++++++++++
 tb/tb_cmp_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare scheduler.
//   cmp_op_e : operation codes (6-7 are illegal, single pass, result 0)
//   state_e  : scheduler FSM states
//   CMP_W    : default operand width
package cmp_pkg;

    localparam int unsigned CMP_W = 16;

    typedef enum logic [2:0] {
        CMP_GT = 3'd0,
        CMP_LT = 3'd1,
        CMP_GE = 3'd2,
        CMP_LE = 3'd3,
        CMP_EQ = 3'd4,
        CMP_NE = 3'd5
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cmp_gt.sv
// Combinational greater-than comparator shared by both requesters.
// Ports:
//   i_x, i_y : operands
//   i_uns    : 1 = unsigned compare, 0 = two's-complement signed compare
//   o_gt     : i_x > i_y
module cmp_gt
    import cmp_pkg::*;
#(
    parameter int unsigned W = CMP_W
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_uns,
    output logic         o_gt
);

    always_comb begin
        if (i_uns) begin
            o_gt = (i_x > i_y);
        end else begin
            o_gt = ($signed(i_x) > $signed(i_y));
        end
    end

endmodule

// File: rtl/cmp_sched.sv
// Two-requester scheduler sharing one signed greater-than comparator between
// the branch unit (port 0) and the ALU set-less-than path (port 1).
// Round-robin valid/ready request side, one or two comparator passes per
// operation, held response channel tagged with the requester ID.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid / req_ready   : per-port request handshake (ready one-hot or 0)
//   reqN_a, reqN_b, reqN_op : port N operands and operation
//   reqN_uns                : port N unsigned select (CMP_SCHED_UNSIGNED_EN only)
//   rsp_valid / rsp_ready   : response handshake, response held until taken
//   rsp_id, rsp_result      : issuing port and single-bit result
// Build option: define CMP_SCHED_UNSIGNED_EN to add the unsigned-select inputs.
module cmp_sched
    import cmp_pkg::*;
#(
    parameter int unsigned W = CMP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
`ifdef CMP_SCHED_UNSIGNED_EN
    input  logic         req0_uns,
    input  logic         req1_uns,
`endif
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic         rsp_result
);

    state_e      r_state;
    logic        r_ptr;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [2:0]  r_op;
    logic        r_id;
    logic        r_uns;
    logic        r_p1;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic        r_rsp_result;

    logic        w_sel;
    logic        w_accept;
    logic        w_uns_in;
    logic        w_two_pass;
    logic        w_swap;
    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic        w_gt;
    logic        w_single_res;
    logic        w_double_res;

    // Both valid: the port other than the pointer wins; otherwise the lone
    // valid port wins (req_valid[1] names it when exactly one bit is set).
    assign w_sel     = (req_valid == 2'b11) ? ~r_ptr : req_valid[1];
    assign req_ready = ((r_state == ST_IDLE) && (req_valid != 2'b00))
                       ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_accept  = (req_ready != 2'b00);

`ifdef CMP_SCHED_UNSIGNED_EN
    assign w_uns_in = w_sel ? req1_uns : req0_uns;
`else
    assign w_uns_in = 1'b0;
`endif

    assign w_two_pass = (r_op == CMP_EQ) || (r_op == CMP_NE);

    // Pass 2 always evaluates gt(b,a); in pass 1 only LT and GE need the
    // swapped order, the rest use gt(a,b).
    assign w_swap = (r_state == ST_PASS2) || (r_op == CMP_LT) || (r_op == CMP_GE);
    assign w_x    = w_swap ? r_b : r_a;
    assign w_y    = w_swap ? r_a : r_b;

    cmp_gt #(.W(W)) u_gt (
        .i_x   (w_x),
        .i_y   (w_y),
        .i_uns (r_uns),
        .o_gt  (w_gt)
    );

    always_comb begin
        w_single_res = 1'b0;
        case (r_op)
            CMP_GT, CMP_LT: w_single_res = w_gt;
            CMP_GE, CMP_LE: w_single_res = ~w_gt;
            default:        w_single_res = 1'b0;
        endcase
    end

    always_comb begin
        w_double_res = 1'b0;
        if (r_op == CMP_EQ) begin
            w_double_res = ~(r_p1 | w_gt);
        end else if (r_op == CMP_NE) begin
            w_double_res = r_p1 | w_gt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_uns        <= 1'b0;
            r_p1         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel ? req1_a  : req0_a;
                        r_b     <= w_sel ? req1_b  : req0_b;
                        r_op    <= w_sel ? req1_op : req0_op;
                        r_id    <= w_sel;
                        r_uns   <= w_uns_in;
                        r_ptr   <= w_sel;
                        r_state <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    if (w_two_pass) begin
                        r_p1    <= w_gt;
                        r_state <= ST_PASS2;
                    end else begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_id;
                        r_rsp_result <= w_single_res;
                        r_state      <= ST_DONE;
                    end
                end
                ST_PASS2: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_result <= w_double_res;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;

endmodule

// File: tb/tb_cmp_sched.sv
// Self-checking bench for cmp_sched: vector table through a scoreboard,
// plus sequences for round-robin, response hold and mid-operation reset.
module tb_cmp_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
`ifdef CMP_SCHED_UNSIGNED_EN
    logic        req0_uns, req1_uns;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic        rsp_result;

    cmp_sched #(.W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
`ifdef CMP_SCHED_UNSIGNED_EN
        .req0_uns   (req0_uns),
        .req1_uns   (req1_uns),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        bit          uns;
        bit          exp;
    } vec_t;

    typedef struct {
        bit          id;
        bit          res;
        int unsigned t;
        int unsigned lat;
    } sb_t;

    vec_t tbl[13];
    sb_t  sb[$];
    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_port(input bit port, input logic [2:0] op,
                              input logic [15:0] a, input logic [15:0] b, input bit uns);
        if (port == 1'b0) begin
            req0_a = a; req0_b = b; req0_op = op;
`ifdef CMP_SCHED_UNSIGNED_EN
            req0_uns = uns;
`endif
        end else begin
            req1_a = a; req1_b = b; req1_op = op;
`ifdef CMP_SCHED_UNSIGNED_EN
            req1_uns = uns;
`endif
        end
        if (uns) begin end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit port, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input bit uns, input bit exp,
                         output int unsigned t_acc);
        sb_t e;
        bit  got;
        got = 1'b0;
        t_acc = 0;
        drive_port(port, op, a, b, uns);
        req_valid[port] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[port]) begin
                got = 1'b1;
                t_acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.id  = port;
            e.res = exp;
            e.t   = t_acc;
            e.lat = (op == 3'd4 || op == 3'd5) ? 2'd3 : 2'd2;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid[port] = 1'b0;
    endtask

    task automatic check_rsp();
        sb_t e;
        if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            chk("rsp_result", {31'd0, rsp_result}, {31'd0, e.res});
            chk("rsp_latency", cyc - e.t, e.lat);
        end
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        else check_rsp();
    endtask

    int unsigned t_a, t_b, t_hs;
    int unsigned grants;
    int unsigned rsps;
    int unsigned onehot_bad;
    int unsigned spurious;
    bit          gport[4];

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 16'h0005, 16'hFFFE, 1'b0, 1'b1}; // GT 5 > -2
        tbl[1]  = '{1'b1, 3'd4, 16'h1234, 16'h1234, 1'b0, 1'b1}; // EQ equal
        tbl[2]  = '{1'b1, 3'd4, 16'h1234, 16'h1235, 1'b0, 1'b0}; // EQ differ
        tbl[3]  = '{1'b0, 3'd1, 16'h8000, 16'h0000, 1'b0, 1'b1}; // LT min < 0
        tbl[4]  = '{1'b1, 3'd2, 16'h7FFF, 16'h8000, 1'b0, 1'b1}; // GE max >= min
        tbl[5]  = '{1'b0, 3'd3, 16'h8000, 16'h0000, 1'b0, 1'b1}; // LE
        tbl[6]  = '{1'b1, 3'd5, 16'h0001, 16'h0001, 1'b0, 1'b0}; // NE equal
        tbl[7]  = '{1'b0, 3'd5, 16'hFFFF, 16'h0001, 1'b0, 1'b1}; // NE differ
        tbl[8]  = '{1'b0, 3'd2, 16'h0003, 16'h0003, 1'b0, 1'b1}; // GE equal
        tbl[9]  = '{1'b1, 3'd1, 16'h0003, 16'h0003, 1'b0, 1'b0}; // LT equal
        tbl[10] = '{1'b0, 3'd6, 16'h0001, 16'h0000, 1'b0, 1'b0}; // illegal
        tbl[11] = '{1'b1, 3'd7, 16'h0000, 16'h0001, 1'b0, 1'b0}; // illegal
`ifdef CMP_SCHED_UNSIGNED_EN
        tbl[12] = '{1'b0, 3'd0, 16'h8000, 16'h0001, 1'b1, 1'b1}; // GT unsigned
`else
        tbl[12] = '{1'b0, 3'd0, 16'h8000, 16'h0001, 1'b0, 1'b0}; // GT signed
`endif

        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
`ifdef CMP_SCHED_UNSIGNED_EN
        req0_uns = 1'b0; req1_uns = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("reset_rsp_result", {31'd0, rsp_result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin: both ports valid from reset.
        drive_port(1'b0, 3'd0, 16'h0005, 16'hFFFE, 1'b0); // port 0 result 1
        drive_port(1'b1, 3'd1, 16'h0005, 16'hFFFE, 1'b0); // port 1 result 0
        @(negedge clk);
        req_valid = 2'b11;
        grants = 0; rsps = 0; onehot_bad = 0;
        for (int i = 0; i < 60 && rsps < 4; i++) begin
            if (grants == 4) req_valid = 2'b00;
            #1;
            if (rsp_valid) begin
                check_rsp();
                rsps++;
            end
            if (req_ready == 2'b11) onehot_bad++;
            if (req_ready != 2'b00 && grants < 4) begin
                sb_t e;
                gport[grants] = req_ready[1];
                e.id = req_ready[1];
                e.res = ~req_ready[1];
                e.t = cyc;
                e.lat = 2;
                sb.push_back(e);
                grants++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_rsp_count", rsps, 32'd4);
        chk("rr_onehot", onehot_bad, 32'd0);
        chk("rr_grant0", {31'd0, gport[0]}, 32'd0);
        chk("rr_grant1", {31'd0, gport[1]}, 32'd1);
        chk("rr_grant2", {31'd0, gport[2]}, 32'd0);
        chk("rr_grant3", {31'd0, gport[3]}, 32'd1);
        sb.delete();
        @(negedge clk);

        // Table vectors, rsp_ready held high.
        foreach (tbl[k]) begin
            issue(tbl[k].port, tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].uns, tbl[k].exp, t_a);
            wait_rsp();
        end
`ifdef CMP_SCHED_UNSIGNED_EN
        issue(1'b1, 3'd0, 16'h8000, 16'h0001, 1'b0, 1'b0, t_a);
        wait_rsp();
`endif
        @(negedge clk);

        // Response held while rsp_ready is low.
        rsp_ready = 1'b0;
        issue(1'b0, 3'd3, 16'h8000, 16'h0000, 1'b0, 1'b1, t_a);
        wait_rsp();
        drive_port(1'b1, 3'd0, 16'h0005, 16'hFFFE, 1'b0);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_id", {31'd0, rsp_id}, 32'd0);
            chk("hold_rsp_result", {31'd0, rsp_result}, 32'd1);
            chk("hold_req_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        t_hs = cyc;
        issue(1'b1, 3'd0, 16'h0005, 16'hFFFE, 1'b0, 1'b1, t_b);
        chk("turnaround", t_b - t_hs, 32'd1);
        wait_rsp();
        @(negedge clk);

        // Reset during PASS2 of an NE request.
        issue(1'b0, 3'd5, 16'h0001, 16'h0002, 1'b0, 1'b1, t_a);
        @(negedge clk);
        chk("pre_reset_cycle", cyc - t_a, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("midrst_rsp_result", {31'd0, rsp_result}, 32'd0);
        chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) spurious++;
        end
        chk("midrst_no_rsp", spurious, 32'd0);
        @(negedge clk);
        issue(1'b1, 3'd2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, t_a);
        wait_rsp();
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
